xm_run_ctrl: RTL and testbench
==============================

# xm_run_ctrl

Parametrised run-control unit for the XMakina multi-cycle CPU, sitting between the board-level debug controls and the CPU control unit. It holds the CPU halted in a debug view, releases it for an N-instruction step or for free run, and re-halts at instruction boundaries on step-count exhaustion, a stop request, or a PC breakpoint match. It supersedes the fixed single-step debugger with programmable step counts, a breakpoint table and a continuous-run mode.

## Interface
- ADDR_W, 16, width of the PC and breakpoint addresses
- NUM_BP, 4, number of breakpoint registers (≥1)
- STEP_W, 8, width of the step-count input and counter
- BP_IDX_W (localparam), max(1, $clog2(NUM_BP))

- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- step_i  in  1  step request level, synchronous to clk_i, rising-edge detected
- run_i  in  1  free-run request level, rising-edge detected
- stop_i  in  1  stop request level, sampled every cycle
- step_cnt_i  in  STEP_W  instructions per step request; 0 treated as 1
- instr_done_i  in  1  one-cycle pulse from CPU control at each instruction boundary
- pc_i  in  ADDR_W  address of the next instruction; valid with instr_done_i
- bp_we_i  in  1  breakpoint table write strobe
- bp_idx_i  in  BP_IDX_W  entry to write
- bp_addr_i  in  ADDR_W  breakpoint address
- bp_en_i  in  1  entry enable
- halt_o  out  1  CPU must not start a new instruction while high
- view_o  out  1  debug view active (register/memory inspection allowed)
- bp_hit_o  out  1  one-cycle pulse: halted on a breakpoint
- bp_id_o  out  BP_IDX_W  index of the last breakpoint hit, held until the next hit

## Operation
- States: DEBUG, STEP, RUN. Reset state is DEBUG.
- Reset values: halt_o=1, view_o=1, bp_hit_o=0, bp_id_o=0, step counter=0, stop_pend=0, all breakpoint entries disabled with address 0, edge-detect registers=1.
- Edge-detect registers reset to 1 so that a button held through reset does not trigger.
- DEBUG: halt_o=1, view_o=1.
  - step rise: load counter with max(step_cnt_i,1) and go to STEP.
  - run rise: go to RUN.
  - Simultaneous step and run rises: step wins.
  - stop_i is ignored and clears stop_pend.
- STEP: halt_o=0, view_o=0. On instr_done_i, the counter decrements. Return to DEBUG when any of the following holds:
  - counter==1;
  - breakpoint hit;
  - stop_pend or stop_i.
- RUN: halt_o=0, view_o=0. On instr_done_i, return to DEBUG on a breakpoint hit or on stop_pend or stop_i.
- step and run rises are ignored outside DEBUG.
- stop_i high in STEP or RUN sets stop_pend. The halt is taken only at the next instr_done_i, never mid-instruction.
- Breakpoint hit:
  - Condition: instr_done_i in STEP or RUN, and an enabled entry has address == pc_i.
  - The CPU halts before executing pc_i.
  - bp_hit_o pulses the following cycle; bp_id_o takes the lowest matching index.
  - Resuming from a breakpoint does not re-trigger, because the next compare uses the following PC.
- Breakpoint writes are accepted in any state and take effect for compares from the next cycle. A write and a compare on the same entry in the same cycle use the old value.

## Timing
- All outputs are registered or state-decoded. There is no combinational input-to-output path.
- step_i rises, sampled at edge n: halt_o is low from cycle n+1.
- instr_done_i that ends a step or run, sampled at edge n: halt_o is high from cycle n+1.
  - CPU control samples halt_o in its fetch state, which occurs at least one cycle after instr_done_i.
- instr_done_i outside STEP or RUN is ignored.
- Asynchronous reset mid-STEP or mid-RUN: state goes to DEBUG immediately, halt_o=1, and stop_pend and the counter are cleared.

## Structure
- Package xm_debug_pkg holds:
  - run_state_t enum {DEBUG, STEP, RUN} (2-bit);
  - the breakpoint entry struct {en, addr}.
- Sub-module xm_bp_match holds the NUM_BP comparators plus the lowest-index priority encoder, with outputs hit and idx. It is purely combinational and instantiated once.

## Test plan
- Reset with step_i held high, then release and press: exactly one step. With step_cnt_i=3, three instr_done_i pulses bring halt_o high, then view_o=1.
- step_cnt_i=0 with a step press: halts after exactly one instr_done_i.
- run press with bp[2]=0x0040 enabled and pc_i sequence 0x3E, 0x40: halts at 0x40, bp_hit_o pulses once, bp_id_o=2. A second run press continues past 0x40.
- bp[1] and bp[3] both set to 0x0100: hit reports bp_id_o=1. A disabled entry matching pc_i produces no hit.
- stop_i pulsed mid-instruction in RUN: halt_o stays 0 until the next instr_done_i, then goes high one cycle later.
- rst_ni asserted during STEP with 5 steps left: halt_o=1 asynchronously. After release, the next step press with step_cnt_i=1 runs one instruction.

Source files
------------

// File: rtl/xm_debug_pkg.sv
// Shared types for the XMakina run-control block: run states and breakpoint entries.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package xm_debug_pkg;

  typedef enum logic [1:0] {
    DEBUG = 2'd0,
    STEP  = 2'd1,
    RUN   = 2'd2
  } run_state_t;

  // Breakpoint addresses are stored zero-extended to this width so the entry
  // type can be shared by any instance with ADDR_W up to 32.
  localparam int BP_ADDR_MAX_W = 32;

  typedef struct packed {
    logic                     en;
    logic [BP_ADDR_MAX_W-1:0] addr;
  } bp_entry_t;

endpackage

// File: rtl/xm_bp_match.sv
// Breakpoint comparators with lowest-index priority encode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   bp_tab  breakpoint table (enable + address per entry)
//   pc      address to compare against every enabled entry
//   hit     some enabled entry matches pc
//   idx     lowest matching entry index (0 when no hit)
module xm_bp_match
  import xm_debug_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int NUM_BP   = 4,
  parameter int BP_IDX_W = 2
) (
  input  bp_entry_t           bp_tab [NUM_BP],
  input  logic [ADDR_W-1:0]   pc,
  output logic                hit,
  output logic [BP_IDX_W-1:0] idx
);

  logic [BP_ADDR_MAX_W-1:0] pc_ext;

  always_comb begin
    pc_ext = BP_ADDR_MAX_W'(pc);
    hit    = 1'b0;
    idx    = '0;
    // Walk from the top so the lowest matching index is the last one written.
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_tab[i].en && (bp_tab[i].addr == pc_ext)) begin
        hit = 1'b1;
        idx = BP_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/xm_run_ctrl.sv
// Run control for the XMakina CPU: debug halt, N-instruction step, free run, breakpoints.
// Latency: one cycle from a step/run rise or a terminating instr_done_i to halt_o.
// Backpressure: none; halts are only taken at instruction boundaries (instr_done_i).
//
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   step_i, run_i               debug buttons (rising-edge detected)
//   stop_i                      stop request level
//   step_cnt_i                  instructions per step (0 acts as 1)
//   instr_done_i, pc_i          instruction boundary pulse and next PC from CPU control
//   bp_we_i, bp_idx_i,
//   bp_addr_i, bp_en_i          breakpoint table write port
//   halt_o, view_o              CPU hold and debug-view indicators
//   bp_hit_o, bp_id_o           breakpoint halt pulse and last hit index
module xm_run_ctrl
  import xm_debug_pkg::*;
#(
  parameter  int ADDR_W   = 16,
  parameter  int NUM_BP   = 4,
  parameter  int STEP_W   = 8,
  localparam int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                step_i,
  input  logic                run_i,
  input  logic                stop_i,
  input  logic [STEP_W-1:0]   step_cnt_i,
  input  logic                instr_done_i,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic                bp_we_i,
  input  logic [BP_IDX_W-1:0] bp_idx_i,
  input  logic [ADDR_W-1:0]   bp_addr_i,
  input  logic                bp_en_i,
  output logic                halt_o,
  output logic                view_o,
  output logic                bp_hit_o,
  output logic [BP_IDX_W-1:0] bp_id_o
);

  run_state_t          state_q, state_d;
  logic [STEP_W-1:0]   cnt_q, cnt_d;
  logic                stop_pend_q, stop_pend_d;
  logic                step_q, run_q;
  bp_entry_t           bp_tab_q [NUM_BP];
  logic                bp_hit_q;
  logic [BP_IDX_W-1:0] bp_id_q;

  logic                match_hit;
  logic [BP_IDX_W-1:0] match_idx;
  logic                step_rise, run_rise, bp_evt;

  xm_bp_match #(
    .ADDR_W   (ADDR_W),
    .NUM_BP   (NUM_BP),
    .BP_IDX_W (BP_IDX_W)
  ) u_bp_match (
    .bp_tab (bp_tab_q),
    .pc     (pc_i),
    .hit    (match_hit),
    .idx    (match_idx)
  );

  assign step_rise = step_i & ~step_q;
  assign run_rise  = run_i & ~run_q;
  assign bp_evt    = instr_done_i & (state_q != DEBUG) & match_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    unique case (state_q)
      DEBUG: begin
        if (step_rise) begin
          state_d = STEP;
          cnt_d   = (step_cnt_i == '0) ? STEP_W'(1) : step_cnt_i;
        end else if (run_rise) begin
          state_d = RUN;
        end
      end
      STEP: begin
        if (instr_done_i) begin
          cnt_d = cnt_q - STEP_W'(1);
          if ((cnt_q == STEP_W'(1)) || match_hit || stop_pend_q || stop_i) begin
            state_d = DEBUG;
          end
        end else if (stop_i) begin
          stop_pend_d = 1'b1;
        end
      end
      RUN: begin
        if (instr_done_i) begin
          if (match_hit || stop_pend_q || stop_i) begin
            state_d = DEBUG;
          end
        end else if (stop_i) begin
          stop_pend_d = 1'b1;
        end
      end
      default: state_d = DEBUG;
    endcase
    // A pending stop never survives into DEBUG; stop_i in DEBUG is dropped here too.
    if (state_d == DEBUG) begin
      stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DEBUG;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      // Held at 1 so a button already pressed during reset does not count as a rise.
      step_q      <= 1'b1;
      run_q       <= 1'b1;
      bp_hit_q    <= 1'b0;
      bp_id_q     <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        bp_tab_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      step_q      <= step_i;
      run_q       <= run_i;
      bp_hit_q    <= bp_evt;
      if (bp_evt) begin
        bp_id_q <= match_idx;
      end
      // Compare above used the pre-write table, so same-cycle writes apply next cycle.
      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_we_i && (bp_idx_i == BP_IDX_W'(i))) begin
          bp_tab_q[i] <= '{en: bp_en_i, addr: BP_ADDR_MAX_W'(bp_addr_i)};
        end
      end
    end
  end

  assign halt_o   = (state_q == DEBUG);
  assign view_o   = (state_q == DEBUG);
  assign bp_hit_o = bp_hit_q;
  assign bp_id_o  = bp_id_q;

endmodule

// File: tb/tb_xm_run_ctrl.sv
module tb_xm_run_ctrl;

  localparam int ADDR_W   = 16;
  localparam int NUM_BP   = 4;
  localparam int STEP_W   = 8;
  localparam int BP_IDX_W = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                step_i = 1'b0;
  logic                run_i = 1'b0;
  logic                stop_i = 1'b0;
  logic [STEP_W-1:0]   step_cnt_i = '0;
  logic                instr_done_i = 1'b0;
  logic [ADDR_W-1:0]   pc_i = '0;
  logic                bp_we_i = 1'b0;
  logic [BP_IDX_W-1:0] bp_idx_i = '0;
  logic [ADDR_W-1:0]   bp_addr_i = '0;
  logic                bp_en_i = 1'b0;
  logic                halt_o, view_o, bp_hit_o;
  logic [BP_IDX_W-1:0] bp_id_o;

  xm_run_ctrl #(.ADDR_W(ADDR_W), .NUM_BP(NUM_BP), .STEP_W(STEP_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .step_i(step_i), .run_i(run_i), .stop_i(stop_i),
    .step_cnt_i(step_cnt_i), .instr_done_i(instr_done_i), .pc_i(pc_i),
    .bp_we_i(bp_we_i), .bp_idx_i(bp_idx_i), .bp_addr_i(bp_addr_i), .bp_en_i(bp_en_i),
    .halt_o(halt_o), .view_o(view_o), .bp_hit_o(bp_hit_o), .bp_id_o(bp_id_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: "halted" flag, remaining instruction budget (or free run),
  // a sticky stop flag and a plain array breakpoint table.
  bit m_halted, m_free, m_stop_seen, m_step_prev, m_run_prev, m_pulse;
  int m_left, m_id;
  bit m_bp_en [NUM_BP];
  int m_bp_addr [NUM_BP];

  task automatic model_reset();
    m_halted = 1; m_free = 0; m_stop_seen = 0; m_left = 0;
    m_step_prev = 1; m_run_prev = 1; m_pulse = 0; m_id = 0;
    for (int i = 0; i < NUM_BP; i++) begin m_bp_en[i] = 0; m_bp_addr[i] = 0; end
  endtask

  task automatic model_edge();
    int first;
    bit srise, rrise;
    srise = step_i && !m_step_prev;
    rrise = run_i && !m_run_prev;
    m_pulse = 0;
    if (m_halted) begin
      m_stop_seen = 0;
      if (srise) begin
        m_halted = 0; m_free = 0;
        m_left = (step_cnt_i == 0) ? 1 : int'(step_cnt_i);
      end else if (rrise) begin
        m_halted = 0; m_free = 1;
      end
    end else if (instr_done_i) begin
      first = -1;
      for (int i = 0; i < NUM_BP; i++)
        if (first < 0 && m_bp_en[i] && m_bp_addr[i] == int'(pc_i)) first = i;
      if (!m_free) m_left = m_left - 1;
      if (first >= 0) begin m_pulse = 1; m_id = first; end
      if (first >= 0 || m_stop_seen || stop_i || (!m_free && m_left == 0)) begin
        m_halted = 1; m_stop_seen = 0;
      end
    end else if (stop_i) begin
      m_stop_seen = 1;
    end
    if (bp_we_i) begin
      m_bp_en[bp_idx_i] = bp_en_i;
      m_bp_addr[bp_idx_i] = int'(bp_addr_i);
    end
    m_step_prev = step_i;
    m_run_prev = run_i;
  endtask

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic step_clk();
    @(posedge clk_i);
    if (rst_ni) model_edge();
    #1;
  endtask

  task automatic press_step(input int cnt);
    step_cnt_i = STEP_W'(cnt); step_i = 1; step_clk(); step_i = 0;
  endtask

  task automatic press_run();
    run_i = 1; step_clk(); run_i = 0;
  endtask

  task automatic instr(input int pc);
    instr_done_i = 1; pc_i = ADDR_W'(pc); step_clk(); instr_done_i = 0;
  endtask

  task automatic bp_write(input int idx, input int addr, input bit en);
    bp_we_i = 1; bp_idx_i = BP_IDX_W'(idx); bp_addr_i = ADDR_W'(addr); bp_en_i = en;
    step_clk(); bp_we_i = 0;
  endtask

  task automatic do_reset();
    rst_ni = 0; model_reset();
    repeat (2) step_clk();
    rst_ni = 1;
  endtask

  task automatic test_reset();
    step_i = 1; run_i = 1;
    do_reset();
    repeat (3) step_clk();
    n_chk++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL reset_halt: got %b want 1", halt_o); end
    n_chk++; if (view_o !== 1'b1) begin n_fail++; $display("FAIL reset_view: got %b want 1", view_o); end
    n_chk++; if (bp_hit_o !== 1'b0) begin n_fail++; $display("FAIL reset_bp_hit: got %b want 0", bp_hit_o); end
    n_chk++; if (bp_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_bp_id: got %0d want 0", bp_id_o); end
    step_i = 0; run_i = 0;
    step_clk();
  endtask

  task automatic test_step_count();
    press_step(3);
    n_chk++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL step3_start: halt got %b want 0", halt_o); end
    for (int k = 1; k <= 3; k++) begin
      step_clk();
      instr(16 + 2 * k);
      n_chk++;
      if (halt_o !== (k == 3)) begin
        n_fail++; $display("FAIL step3_instr%0d: halt got %b want %0d", k, halt_o, (k == 3));
      end
    end
    n_chk++; if (view_o !== 1'b1) begin n_fail++; $display("FAIL step3_view: got %b want 1", view_o); end
  endtask

  task automatic test_step_zero();
    press_step(0);
    n_chk++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL step0_start: halt got %b want 0", halt_o); end
    instr(32);
    n_chk++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL step0_end: halt got %b want 1", halt_o); end
  endtask

  task automatic test_breakpoint_run();
    bp_write(2, 'h40, 1);
    press_run();
    instr('h3E);
    n_chk++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL bp_pre_halt: got %b want 0", halt_o); end
    instr('h40);
    n_chk++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL bp_halt: got %b want 1", halt_o); end
    n_chk++; if (bp_hit_o !== 1'b1) begin n_fail++; $display("FAIL bp_pulse: got %b want 1", bp_hit_o); end
    n_chk++; if (bp_id_o !== 2'd2) begin n_fail++; $display("FAIL bp_id2: got %0d want 2", bp_id_o); end
    step_clk();
    n_chk++; if (bp_hit_o !== 1'b0) begin n_fail++; $display("FAIL bp_pulse_once: got %b want 0", bp_hit_o); end
    press_run();
    instr('h42);
    n_chk++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL bp_resume: halt got %b want 0", halt_o); end
  endtask

  // Continues from free run left by the breakpoint test.
  task automatic test_stop_mid_instr();
    stop_i = 1; step_clk(); stop_i = 0;
    for (int k = 0; k < 3; k++) begin
      step_clk();
      n_chk++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL stop_wait%0d: halt got %b want 0", k, halt_o); end
    end
    instr('h44);
    n_chk++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL stop_halt: got %b want 1", halt_o); end
  endtask

  task automatic test_bp_priority();
    bp_write(2, 0, 0);
    bp_write(1, 'h100, 1);
    bp_write(3, 'h100, 1);
    bp_write(0, 'h100, 0);
    press_run();
    instr('h100);
    n_chk++; if (bp_hit_o !== 1'b1 || bp_id_o !== 2'd1) begin
      n_fail++; $display("FAIL bp_prio: hit %b id %0d want hit 1 id 1", bp_hit_o, bp_id_o);
    end
    bp_write(1, 'h100, 0);
    bp_write(3, 'h100, 0);
    press_run();
    instr('h100);
    n_chk++; if (halt_o !== 1'b0 || bp_hit_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_disabled: halt %b hit %b want 0 0", halt_o, bp_hit_o);
    end
    stop_i = 1; instr('h102); stop_i = 0;
    n_chk++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL stop_with_done: halt got %b want 1", halt_o); end
  endtask

  task automatic test_async_reset();
    press_step(7);
    instr('h10);
    instr('h12);
    #2 rst_ni = 0;
    #1;
    n_chk++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL async_rst_halt: got %b want 1", halt_o); end
    model_reset();
    step_clk();
    @(negedge clk_i); rst_ni = 1;
    step_clk();
    press_step(1);
    n_chk++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_start: halt got %b want 0", halt_o); end
    instr('h20);
    n_chk++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_one: halt got %b want 1", halt_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) step_i = ~step_i;
      if ($urandom_range(0, 24) == 0) run_i = ~run_i;
      stop_i       = ($urandom_range(0, 39) == 0);
      step_cnt_i   = STEP_W'($urandom_range(0, 4));
      instr_done_i = ($urandom_range(0, 2) == 0);
      pc_i         = ADDR_W'('h10 + $urandom_range(0, 7));
      bp_we_i      = ($urandom_range(0, 29) == 0);
      bp_idx_i     = BP_IDX_W'($urandom_range(0, NUM_BP - 1));
      bp_addr_i    = ADDR_W'('h10 + $urandom_range(0, 7));
      bp_en_i      = $urandom_range(0, 1) == 1;
      step_clk();
      n_chk++; if (halt_o !== m_halted || view_o !== m_halted) begin
        n_fail++; $display("FAIL rnd_halt c=%0d: halt %b view %b want %b", c, halt_o, view_o, m_halted);
      end
      n_chk++; if (bp_hit_o !== m_pulse) begin
        n_fail++; $display("FAIL rnd_bp_hit c=%0d: got %b want %b", c, bp_hit_o, m_pulse);
      end
      n_chk++; if (int'(bp_id_o) != m_id) begin
        n_fail++; $display("FAIL rnd_bp_id c=%0d: got %0d want %0d", c, bp_id_o, m_id);
      end
    end
    instr_done_i = 0; stop_i = 0; bp_we_i = 0;
  endtask

  initial begin
    test_reset();
    test_step_count();
    test_step_zero();
    test_breakpoint_run();
    test_stop_mid_instr();
    test_bp_priority();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
